// File: rtl/gpu_video_pkg.sv
// Shared video timing constants, sync positions and the decoded control bundle.
// The rasterizer imports the same constants so its bounds match the scanout.
package gpu_video_pkg;

    localparam int VID_H_ACTIVE = 640;
    localparam int VID_H_FP     = 16;
    localparam int VID_H_SYNC   = 96;
    localparam int VID_H_BP     = 48;
    localparam int VID_V_ACTIVE = 480;
    localparam int VID_V_FP     = 10;
    localparam int VID_V_SYNC   = 2;
    localparam int VID_V_BP     = 33;

    localparam int VID_H_TOTAL = VID_H_ACTIVE + VID_H_FP + VID_H_SYNC + VID_H_BP;
    localparam int VID_V_TOTAL = VID_V_ACTIVE + VID_V_FP + VID_V_SYNC + VID_V_BP;

    // Sync windows are half-open: [start, end).
    localparam int VID_H_SYNC_START = VID_H_ACTIVE + VID_H_FP;
    localparam int VID_H_SYNC_END   = VID_H_SYNC_START + VID_H_SYNC;
    localparam int VID_V_SYNC_START = VID_V_ACTIVE + VID_V_FP;
    localparam int VID_V_SYNC_END   = VID_V_SYNC_START + VID_V_SYNC;

    localparam int VID_ADDR_W = 19;

    typedef struct packed {
        logic active;
        logic hsync_n;
        logic vsync_n;
        logic vblank;
    } vid_ctl_t;

    localparam vid_ctl_t VID_CTL_RESET = '{active: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1, vblank: 1'b0};

    function automatic logic in_span(input int pos, input int lo, input int hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters plus undelayed active/sync/vblank decode of the current position.
// Latency 0 (decode is combinational on the counters); advances only when pix_en=1.
module vga_timing_gen
    import gpu_video_pkg::*;
#(
    parameter int H_ACTIVE = VID_H_ACTIVE,
    parameter int V_ACTIVE = VID_V_ACTIVE,
    parameter int H_TOTAL  = VID_H_TOTAL,
    parameter int V_TOTAL  = VID_V_TOTAL,
    parameter int HS_START = VID_H_SYNC_START,
    parameter int HS_END   = VID_H_SYNC_END,
    parameter int VS_START = VID_V_SYNC_START,
    parameter int VS_END   = VID_V_SYNC_END,
    parameter int HCW      = $clog2(VID_H_TOTAL),
    parameter int VCW      = $clog2(VID_V_TOTAL)
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     pix_en,
    output vid_ctl_t ctl,
    output logic     frame_end
);

    logic [HCW-1:0] hcount_q, hcount_d;
    logic [VCW-1:0] vcount_q, vcount_d;
    logic           line_end;
    logic           last_line;

    assign line_end  = (hcount_q == HCW'(H_TOTAL - 1));
    assign last_line = (vcount_q == VCW'(V_TOTAL - 1));
    assign frame_end = pix_en && line_end && last_line;

    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pix_en) begin
            if (line_end) begin
                hcount_d = '0;
                vcount_d = last_line ? '0 : vcount_q + VCW'(1);
            end else begin
                hcount_d = hcount_q + HCW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    always_comb begin
        ctl         = VID_CTL_RESET;
        ctl.active  = in_span(int'(hcount_q), 0, H_ACTIVE) && in_span(int'(vcount_q), 0, V_ACTIVE);
        ctl.hsync_n = !in_span(int'(hcount_q), HS_START, HS_END);
        ctl.vsync_n = !in_span(int'(vcount_q), VS_START, VS_END);
        ctl.vblank  = (int'(vcount_q) >= V_ACTIVE);
    end

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scanout: raster timing, linear read address, and one-step output alignment.
// Latency 1 enabled step from rd_en to rgb/syncs; never stalls, memory must be fixed single-cycle.
module fb_scanout
    import gpu_video_pkg::*;
#(
    parameter int H_ACTIVE = VID_H_ACTIVE,
    parameter int H_FP     = VID_H_FP,
    parameter int H_SYNC   = VID_H_SYNC,
    parameter int H_BP     = VID_H_BP,
    parameter int V_ACTIVE = VID_V_ACTIVE,
    parameter int V_FP     = VID_V_FP,
    parameter int V_SYNC   = VID_V_SYNC,
    parameter int V_BP     = VID_V_BP
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_en,
    output logic [VID_ADDR_W-1:0] rd_addr,
    output logic                  rd_en,
    input  logic [2:0]            rd_data,
    output logic [2:0]            rgb,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  video_on,
    output logic                  vblank,
    output logic                  frame_done
);

    localparam int HT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HCW = $clog2(HT);
    localparam int VCW = $clog2(VT);

    vid_ctl_t                ctl_raw;
    vid_ctl_t                ctl_q, ctl_d;
    logic                    frame_end;
    logic [VID_ADDR_W-1:0]   addr_q, addr_d;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .H_TOTAL  (HT),
        .V_TOTAL  (VT),
        .HS_START (H_ACTIVE + H_FP),
        .HS_END   (H_ACTIVE + H_FP + H_SYNC),
        .VS_START (V_ACTIVE + V_FP),
        .VS_END   (V_ACTIVE + V_FP + V_SYNC),
        .HCW      (HCW),
        .VCW      (VCW)
    ) u_timing (
        .clk       (clk),
        .rst       (rst),
        .pix_en    (pix_en),
        .ctl       (ctl_raw),
        .frame_end (frame_end)
    );

    // Counters sit at pixel (0,0) during reset, so the strobe is gated by rst itself.
    assign rd_en      = rst && pix_en && ctl_raw.active;
    assign frame_done = rst && frame_end;
    assign rd_addr    = addr_q;

    always_comb begin
        addr_d = addr_q;
        if (frame_end) begin
            addr_d = '0;
        end else if (rd_en) begin
            addr_d = addr_q + VID_ADDR_W'(1);
        end
        ctl_d = pix_en ? ctl_raw : ctl_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
            ctl_q  <= VID_CTL_RESET;
        end else begin
            addr_q <= addr_d;
            ctl_q  <= ctl_d;
        end
    end

    // rd_data already arrives one enabled step after rd_en, matching ctl_q; an
    // extra register here would push colour a step behind the syncs.
    assign rgb      = ctl_q.active ? rd_data : 3'b000;
    assign hsync    = ctl_q.hsync_n;
    assign vsync    = ctl_q.vsync_n;
    assign video_on = ctl_q.active;
    assign vblank   = ctl_q.vblank;

endmodule
